spectrum_peak_finder: RTL and testbench
=======================================

Name: spectrum_peak_finder

Overview:
Sits directly downstream of the FFT core and its magnitude-squared stage. It consumes the per-bin power stream (amp with source_valid/sop/eop) and scans each frame for the strongest bin in the positive-frequency half. After every complete frame it reports that bin's index and power as a one-cycle result, which feeds frequency readout and display logic.

Parameters:
FFT_LEN, 1024, points per FFT frame; power of two.
BIN_W, 10, bin index width, log2(FFT_LEN).
AMP_W, 25, power input width.
DC_SKIP, 2, number of lowest bins excluded from the search (DC leakage).
CNT_W, 16, frame counter width.

Ports:
sys_clk  in  1  system clock; all logic on the rising edge.
sys_rst_n  in  1  asynchronous active-low reset.
source_valid  in  1  power sample valid; FFT output always accepted, no backpressure.
source_sop  in  1  first bin of frame, qualified by source_valid.
source_eop  in  1  last bin of frame, qualified by source_valid.
amp  in  AMP_W  bin power re^2+im^2, treated as unsigned.
peak_valid  out  1  one-cycle pulse: result fields updated.
peak_bin  out  BIN_W  index of the maximum-power bin.
peak_amp  out  AMP_W  power of that bin.
frame_cnt  out  CNT_W  count of good frames reported, wraps.
frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset (async, sys_rst_n=0): FSM to IDLE; bin_idx, cur_max, cur_bin, peak_bin, peak_amp, frame_cnt = 0; peak_valid = frame_err = 0.
- A beat is a cycle with source_valid=1. Non-valid cycles are ignored and state holds.
- FSM:
  - IDLE: a beat with sop starts a frame. That beat becomes bin 0 and the FSM goes to SCAN. Beats without sop are ignored.
  - SCAN: each beat increments bin_idx. A beat with sop restarts the frame: frame_err pulses, bin 0 is reloaded, and the FSM stays in SCAN. A beat with eop goes to REPORT.
  - REPORT: lasts one cycle, then goes to IDLE. A beat with sop arriving in REPORT is accepted as bin 0 of a new frame and the FSM goes to SCAN.
- Search window: bins DC_SKIP through FFT_LEN/2-1 inclusive; all other bins are ignored. The running max is cleared at sop. Comparison is strict >, so on a tie the lowest bin wins.
- An all-zero window yields peak_bin=DC_SKIP and peak_amp=0, because cur_bin initialises to DC_SKIP.
- Good eop: eop arrives on bin FFT_LEN-1. In the next cycle (REPORT), peak_valid=1; peak_bin, peak_amp and frame_cnt+1 are registered on that same edge. Latency from eop beat to peak_valid is 1 cycle.
- Bad eop: eop on any other bin_idx. frame_err pulses for 1 cycle, peak outputs hold and frame_cnt is unchanged.
- Overrun: a beat in SCAN at bin FFT_LEN-1 without eop. frame_err pulses, the FSM goes to IDLE and the frame is discarded.
- sop and eop on the same beat in IDLE: treated as a bad frame; frame_err pulses and the FSM returns to IDLE.
- peak_bin, peak_amp and frame_cnt hold between reports. frame_cnt wraps from 2^CNT_W-1 to 0.

Optional Feature:
Macro PEAK_THRESH_EN.
- Defined: adds input port peak_thresh (AMP_W). On a good frame, peak_valid pulses only if the final peak_amp >= peak_thresh. Otherwise a no_peak output pulses for 1 cycle, peak outputs hold and frame_cnt still increments.
- Undefined: neither port exists and every good frame reports.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE, SCAN, REPORT).
  - Constants HALF_LEN = FFT_LEN/2 and LAST_BIN = FFT_LEN-1.
  - Default widths.
- One natural sub-module: peak_track, the compare-and-hold register for cur_max/cur_bin with clear and update enables. The FSM and counters remain in the top module.

Test Plan:
- Tone frame: 1024 beats, amp=5 everywhere except bin 100 = 40000 -> one cycle after eop, peak_valid=1, peak_bin=100, peak_amp=40000, frame_cnt=1.
- Window edges:
  - bin 1 = 900000 and bin 600 = 800000, rest 10 -> peak_bin at a value ≠1 and ≠600; the only other non-10 bin is bin 511 = 50 -> peak_bin=511.
  - Ties: bins 50 and 80 both 7000 -> peak_bin=50.
- Short frame: eop on bin 700 -> frame_err pulse, no peak_valid, frame_cnt unchanged; the following good frame reports normally.
- Mid-frame sop at bin 300, then a full 1024-beat frame with peak at bin 20 -> frame_err at restart, then peak_bin=20.
- Gapped valid: a random 50% valid duty across the frame, plus reset asserted at bin 400 of a second frame -> first frame gives the correct peak; after reset all outputs are 0 and the next full frame reports frame_cnt=1.
- PEAK_THRESH_EN with peak_thresh=10000: peak 9999 -> no_peak pulse; peak 10000 -> peak_valid pulse.

Source files
------------

// File: rtl/spectrum_peak_finder_pkg.sv
// Shared types and default sizes for the spectrum peak finder.
// Frame geometry constants are derived from the default FFT length.
package spectrum_peak_finder_pkg;

   localparam int DEF_FFT_LEN = 1024;
   localparam int DEF_BIN_W   = 10;
   localparam int DEF_AMP_W   = 25;
   localparam int DEF_DC_SKIP = 2;
   localparam int DEF_CNT_W   = 16;

   localparam int HALF_LEN = DEF_FFT_LEN / 2;
   localparam int LAST_BIN = DEF_FFT_LEN - 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } state_t;

endpackage

// File: rtl/spectrum_peak_finder_if.sv
// Power stream in, peak result out, for the spectrum peak finder.
// Optional PEAK_THRESH_EN adds peak_thresh (in) and no_peak (out).
interface spectrum_peak_finder_if
   import spectrum_peak_finder_pkg::*;
#(
   parameter int AMP_W = DEF_AMP_W,
   parameter int BIN_W = DEF_BIN_W,
   parameter int CNT_W = DEF_CNT_W
);

   logic             source_valid;
   logic             source_sop;
   logic             source_eop;
   logic [AMP_W-1:0] amp;

   logic             peak_valid;
   logic [BIN_W-1:0] peak_bin;
   logic [AMP_W-1:0] peak_amp;
   logic [CNT_W-1:0] frame_cnt;
   logic             frame_err;

`ifdef PEAK_THRESH_EN
   logic [AMP_W-1:0] peak_thresh;
   logic             no_peak;

   modport master (
      output source_valid, source_sop, source_eop, amp, peak_thresh,
      input  peak_valid, peak_bin, peak_amp, frame_cnt, frame_err,
             no_peak
   );

   modport slave (
      input  source_valid, source_sop, source_eop, amp, peak_thresh,
      output peak_valid, peak_bin, peak_amp, frame_cnt, frame_err,
             no_peak
   );
`else
   modport master (
      output source_valid, source_sop, source_eop, amp,
      input  peak_valid, peak_bin, peak_amp, frame_cnt, frame_err
   );

   modport slave (
      input  source_valid, source_sop, source_eop, amp,
      output peak_valid, peak_bin, peak_amp, frame_cnt, frame_err
   );
`endif

endinterface

// File: rtl/spectrum_peak_finder_peak_track.sv
// Running maximum of bin power within one frame.
// clr restarts the search; upd offers the current bin for comparison.
module spectrum_peak_finder_peak_track
   import spectrum_peak_finder_pkg::*;
#(
   parameter int AMP_W   = DEF_AMP_W,
   parameter int BIN_W   = DEF_BIN_W,
   parameter int DC_SKIP = DEF_DC_SKIP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             upd,
   input  logic [AMP_W-1:0] amp,
   input  logic [BIN_W-1:0] bin,
   output logic [AMP_W-1:0] cur_max,
   output logic [BIN_W-1:0] cur_bin
);

   localparam logic [BIN_W-1:0] SKIP_BIN = BIN_W'(DC_SKIP);

   logic [AMP_W-1:0] base_max;
   logic [BIN_W-1:0] base_bin;

   // Compare against an empty window on clear, else the held max
   always_comb begin
      base_max = clr ? '0 : cur_max;
      base_bin = clr ? SKIP_BIN : cur_bin;
   end

   // Strict greater-than keeps the lowest bin on ties
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_max <= '0;
         cur_bin <= '0;
      end else if (upd && (amp > base_max)) begin
         cur_max <= amp;
         cur_bin <= bin;
      end else if (clr) begin
         cur_max <= base_max;
         cur_bin <= base_bin;
      end
   end

endmodule

// File: rtl/spectrum_peak_finder.sv
// Finds the strongest positive-frequency bin of each FFT power frame.
// Optional PEAK_THRESH_EN gates reports on peak_amp >= peak_thresh.
module spectrum_peak_finder
   import spectrum_peak_finder_pkg::*;
#(
   parameter int FFT_LEN = DEF_FFT_LEN,
   parameter int BIN_W   = DEF_BIN_W,
   parameter int AMP_W   = DEF_AMP_W,
   parameter int DC_SKIP = DEF_DC_SKIP,
   parameter int CNT_W   = DEF_CNT_W
) (
   input logic                  sys_clk,
   input logic                  sys_rst_n,
   spectrum_peak_finder_if.slave bus
);

   localparam logic [BIN_W-1:0] LAST = BIN_W'(FFT_LEN - 1);
   localparam logic [BIN_W-1:0] HALF = BIN_W'(FFT_LEN / 2);
   localparam logic [BIN_W-1:0] SKIP = BIN_W'(DC_SKIP);

   state_t           state;
   state_t           next_state;
   logic [BIN_W-1:0] bin_idx;
   logic [BIN_W-1:0] next_bin;
   logic [BIN_W-1:0] beat_bin;
   logic             beat;
   logic             in_win;
   logic             start;
   logic             step;
   logic             good;
   logic             bad;

   logic [AMP_W-1:0] cur_max;
   logic [BIN_W-1:0] cur_bin;

   logic             peak_valid;
   logic [BIN_W-1:0] peak_bin;
   logic [AMP_W-1:0] peak_amp;
   logic [CNT_W-1:0] frame_cnt;
   logic             frame_err;

   assign beat     = bus.source_valid;
   assign next_bin = bin_idx + 1'b1;
   assign beat_bin = start ? '0 : next_bin;
   assign in_win   = (beat_bin >= SKIP) && (beat_bin < HALF);

   // State register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= next_state;
   end

   // Next state from the current beat
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:   if (start) next_state = SCAN;
         SCAN: begin
            if (beat) begin
               if (bus.source_sop)         next_state = SCAN;
               else if (bus.source_eop)    next_state = REPORT;
               else if (next_bin == LAST)  next_state = IDLE;
            end
         end
         REPORT: next_state = start ? SCAN : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Beat classification: frame start, advance, good end, error
   always_comb begin
      start = 1'b0;
      step  = 1'b0;
      good  = 1'b0;
      bad   = 1'b0;
      unique case (state)
         SCAN: begin
            if (beat) begin
               if (bus.source_sop) begin
                  start = 1'b1;
                  bad   = 1'b1;
               end else if (bus.source_eop) begin
                  step = 1'b1;
                  good = (next_bin == LAST);
                  bad  = (next_bin != LAST);
               end else if (next_bin == LAST) begin
                  bad = 1'b1;
               end else begin
                  step = 1'b1;
               end
            end
         end
         default: begin
            if (beat && bus.source_sop) begin
               start = !bus.source_eop;
               bad   = bus.source_eop;
            end
         end
      endcase
   end

   // Bin index of the last accepted beat
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)  bin_idx <= '0;
      else if (start)  bin_idx <= '0;
      else if (step)   bin_idx <= next_bin;
   end

   spectrum_peak_finder_peak_track #(
      .AMP_W   (AMP_W),
      .BIN_W   (BIN_W),
      .DC_SKIP (DC_SKIP)
   ) u_peak_track (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .clr     (start),
      .upd     ((start || step) && in_win),
      .amp     (bus.amp),
      .bin     (beat_bin),
      .cur_max (cur_max),
      .cur_bin (cur_bin)
   );

`ifdef PEAK_THRESH_EN
   logic no_peak;

   // Result registers; weak peaks raise no_peak instead of reporting
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         peak_valid <= 1'b0;
         peak_bin   <= '0;
         peak_amp   <= '0;
         frame_cnt  <= '0;
         frame_err  <= 1'b0;
         no_peak    <= 1'b0;
      end else begin
         peak_valid <= 1'b0;
         no_peak    <= 1'b0;
         frame_err  <= bad;
         if (good) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (cur_max >= bus.peak_thresh) begin
               peak_valid <= 1'b1;
               peak_bin   <= cur_bin;
               peak_amp   <= cur_max;
            end else begin
               no_peak <= 1'b1;
            end
         end
      end
   end

   assign bus.no_peak = no_peak;
`else
   // Result registers, updated on every good frame end
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         peak_valid <= 1'b0;
         peak_bin   <= '0;
         peak_amp   <= '0;
         frame_cnt  <= '0;
         frame_err  <= 1'b0;
      end else begin
         peak_valid <= 1'b0;
         frame_err  <= bad;
         if (good) begin
            frame_cnt  <= frame_cnt + 1'b1;
            peak_valid <= 1'b1;
            peak_bin   <= cur_bin;
            peak_amp   <= cur_max;
         end
      end
   end
`endif

   assign bus.peak_valid = peak_valid;
   assign bus.peak_bin   = peak_bin;
   assign bus.peak_amp   = peak_amp;
   assign bus.frame_cnt  = frame_cnt;
   assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// Directed and random frames against an array-scan peak model.
// Optional PEAK_THRESH_EN also exercises the report threshold.
module tb_spectrum_peak_finder;
   import spectrum_peak_finder_pkg::*;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;

   always #5 sys_clk = ~sys_clk;

   spectrum_peak_finder_if bus ();

   spectrum_peak_finder dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   int unsigned frame_amp [DEF_FFT_LEN];

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   int pv_cnt  = 0;
   int err_cnt = 0;
   int np_cnt  = 0;

   int exp_pv  = 0;
   int exp_err = 0;
   int exp_np  = 0;
   int exp_cnt = 0;
   int unsigned exp_bin = 0;
   int unsigned exp_amp = 0;

   // Count output pulses mid-cycle
   always @(negedge sys_clk) begin
      if (bus.peak_valid) pv_cnt++;
      if (bus.frame_err)  err_cnt++;
`ifdef PEAK_THRESH_EN
      if (bus.no_peak)    np_cnt++;
`endif
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] req);
      n_chk++;
      assert (obs === req) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
      end
   endtask

   function automatic void ref_peak(output int unsigned b,
                                    output int unsigned a);
      b = DEF_DC_SKIP;
      a = 0;
      for (int i = DEF_DC_SKIP; i < HALF_LEN; i++)
         if (frame_amp[i] > a) begin
            a = frame_amp[i];
            b = i;
         end
   endfunction

   function automatic void fill(input int unsigned v);
      foreach (frame_amp[i]) frame_amp[i] = v;
   endfunction

   function automatic void fill_rand();
      foreach (frame_amp[i]) frame_amp[i] = $urandom & 32'h01FF_FFFF;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic beat(input bit sop, input bit eop, input int unsigned a);
      bus.source_valid = 1'b1;
      bus.source_sop   = sop;
      bus.source_eop   = eop;
      bus.amp          = DEF_AMP_W'(a);
      @(posedge sys_clk);
      #1;
      bus.source_valid = 1'b0;
      bus.source_sop   = 1'b0;
      bus.source_eop   = 1'b0;
      bus.amp          = '0;
   endtask

   task automatic send(input int n, input int eop_at, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps)
            for (int g = 0; g < 16 && $urandom_range(0, 1) == 0; g++)
               idle(1);
         beat(i == 0, i == eop_at, frame_amp[i % DEF_FFT_LEN]);
      end
   endtask

   task automatic good_frame(input string tag, input bit gaps);
      int unsigned eb;
      int unsigned ea;
      ref_peak(eb, ea);
      send(DEF_FFT_LEN, LAST_BIN, gaps);
      exp_cnt = (exp_cnt + 1) % 65536;
      exp_pv++;
      check({tag, " peak_valid"}, 32'(bus.peak_valid), 1);
      check({tag, " peak_bin"}, 32'(bus.peak_bin), eb);
      check({tag, " peak_amp"}, 32'(bus.peak_amp), ea);
      check({tag, " frame_cnt"}, 32'(bus.frame_cnt), exp_cnt);
      idle(1);
      check({tag, " pulse end"}, 32'(bus.peak_valid), 0);
      check({tag, " pulses"}, pv_cnt, exp_pv);
      exp_bin = eb;
      exp_amp = ea;
   endtask

   task automatic err_checks(input string tag);
      check({tag, " errs"}, err_cnt, exp_err);
      check({tag, " pulses"}, pv_cnt, exp_pv);
      check({tag, " frame_cnt"}, 32'(bus.frame_cnt), exp_cnt);
      check({tag, " bin hold"}, 32'(bus.peak_bin), exp_bin);
      check({tag, " amp hold"}, 32'(bus.peak_amp), exp_amp);
   endtask

   task automatic zero_checks(input string tag);
      check({tag, " peak_valid"}, 32'(bus.peak_valid), 0);
      check({tag, " peak_bin"}, 32'(bus.peak_bin), 0);
      check({tag, " peak_amp"}, 32'(bus.peak_amp), 0);
      check({tag, " frame_cnt"}, 32'(bus.frame_cnt), 0);
      check({tag, " frame_err"}, 32'(bus.frame_err), 0);
   endtask

   initial begin
      bus.source_valid = 1'b0;
      bus.source_sop   = 1'b0;
      bus.source_eop   = 1'b0;
      bus.amp          = '0;
`ifdef PEAK_THRESH_EN
      bus.peak_thresh  = '0;
`endif

      #12;
      zero_checks("reset");
      idle(1);
      sys_rst_n = 1'b1;
      idle(2);

      fill(5);
      frame_amp[100] = 40000;
      good_frame("tone", 0);
      check("tone bin100", 32'(bus.peak_bin), 100);

      fill(10);
      frame_amp[1]   = 900000;
      frame_amp[600] = 800000;
      frame_amp[511] = 50;
      good_frame("edges", 0);
      check("edges bin511", 32'(bus.peak_bin), 511);

      fill(10);
      frame_amp[50] = 7000;
      frame_amp[80] = 7000;
      good_frame("tie", 0);
      check("tie bin50", 32'(bus.peak_bin), 50);

      fill(0);
      frame_amp[0]    = 123;
      frame_amp[1]    = 456;
      frame_amp[1000] = 789;
      good_frame("zero", 0);
      check("zero bin", 32'(bus.peak_bin), DEF_DC_SKIP);

      for (int k = 0; k < 3; k++) begin
         fill_rand();
         good_frame("rand", 0);
      end

      fill(5);
      send(701, 700, 0);
      exp_err++;
      idle(1);
      err_checks("short");
      fill_rand();
      good_frame("after short", 0);

      fill_rand();
      send(300, -1, 0);
      fill(5);
      frame_amp[20] = 33333;
      send(DEF_FFT_LEN, LAST_BIN, 0);
      exp_err++;
      exp_cnt++;
      exp_pv++;
      idle(1);
      check("restart errs", err_cnt, exp_err);
      check("restart pulses", pv_cnt, exp_pv);
      check("restart bin", 32'(bus.peak_bin), 20);
      check("restart amp", 32'(bus.peak_amp), 33333);
      check("restart cnt", 32'(bus.frame_cnt), exp_cnt);
      exp_bin = 20;
      exp_amp = 33333;

      fill_rand();
      send(1100, -1, 0);
      exp_err++;
      idle(1);
      err_checks("overrun");
      fill_rand();
      good_frame("after overrun", 0);

      beat(1'b1, 1'b1, 77);
      exp_err++;
      idle(1);
      err_checks("sop eop");
      fill_rand();
      good_frame("after sop eop", 0);

      fill_rand();
      good_frame("gapped", 1);
      fill_rand();
      send(400, -1, 1);
      sys_rst_n = 1'b0;
      #2;
      zero_checks("mid reset");
      idle(2);
      sys_rst_n = 1'b1;
      exp_cnt = 0;
      exp_bin = 0;
      exp_amp = 0;
      idle(1);
      fill_rand();
      good_frame("post reset", 0);
      check("post reset cnt1", 32'(bus.frame_cnt), 1);

`ifdef PEAK_THRESH_EN
      bus.peak_thresh = 10000;
      fill(5);
      frame_amp[77] = 9999;
      send(DEF_FFT_LEN, LAST_BIN, 0);
      exp_cnt++;
      exp_np++;
      check("thr low no_peak", 32'(bus.no_peak), 1);
      check("thr low valid", 32'(bus.peak_valid), 0);
      check("thr low cnt", 32'(bus.frame_cnt), exp_cnt);
      check("thr low amp hold", 32'(bus.peak_amp), exp_amp);
      idle(1);
      check("thr low np pulses", np_cnt, exp_np);
      check("thr low pv pulses", pv_cnt, exp_pv);
      fill(5);
      frame_amp[77] = 10000;
      good_frame("thr pass", 0);
      check("thr pass np pulses", np_cnt, exp_np);
      bus.peak_thresh = '0;
`endif

      check("final errs", err_cnt, exp_err);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
